mor1kx_store_buffer_combining: RTL
==================================

# mor1kx_store_buffer_combining

Parametrised register-based store buffer between the LSU and the data bus interface. It queues stores in order and merges a new store into the youngest queued entry when both target the same word. It also reports whether any queued store overlaps a load address, so the LSU can stall loads that would otherwise read stale memory.

## Interface
Parameters:
- DEPTH_WIDTH, 4, log2 of entry count; depth = 2**DEPTH_WIDTH (legal range 1..6).
- OPTION_OPERAND_WIDTH, 32, address/data width (32 or 64); BW = OPTION_OPERAND_WIDTH/8.
- OPTION_STORE_COMBINE, 1, 1 enables merging; 0 gives a plain FIFO.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- pc_i  in  OPTION_OPERAND_WIDTH  PC of the incoming store.
- adr_i  in  OPTION_OPERAND_WIDTH  store address.
- dat_i  in  OPTION_OPERAND_WIDTH  store data, lane-aligned.
- bsel_i  in  BW  byte lane enables.
- atomic_i  in  1  store is l.swa; never merged.
- write_i  in  1  push or merge a store.
- read_i  in  1  pop the head entry.
- pc_o, adr_o, dat_o  out  OPTION_OPERAND_WIDTH  head entry fields.
- bsel_o  out  BW  head entry byte enables.
- atomic_o  out  1  head entry atomic flag.
- snoop_adr_i  in  OPTION_OPERAND_WIDTH  load address to check.
- snoop_hit_o  out  1  a valid entry matches the word address of snoop_adr_i.
- count_o  out  DEPTH_WIDTH+1  number of valid entries.
- full_o  out  1  count_o == depth.
- empty_o  out  1  count_o == 0.

## Operation
- Storage is a circular array of depth entries {adr, dat, bsel, pc, atomic, valid}, indexed by rd_ptr and wr_ptr of DEPTH_WIDTH+1 bits. The MSB distinguishes full from empty. Pointers wrap modulo 2*depth.
- Word match: compare adr[W-1:log2(BW)] and ignore the lane bits.
- A write merges when all of the following hold: OPTION_STORE_COMBINE=1, !empty_o, the tail entry (wr_ptr-1) word-matches adr_i, !atomic_i, the tail entry is not atomic, and !(read_i && count_o==1).
  - On a merge, each lane with bsel_i set takes the dat_i byte.
  - bsel becomes bsel | bsel_i, and pc is replaced by pc_i.
  - wr_ptr and count_o are unchanged.
- Any other write_i allocates a new entry at wr_ptr and increments wr_ptr.
  - If full_o=1 and read_i=0, the write is dropped and state is unchanged. This is illegal usage.
  - If full_o=1 and read_i=1, the write is accepted.
- read_i pops the head by incrementing rd_ptr and clearing that entry's valid bit. read_i while empty_o=1 is ignored.
- When read_i and write_i are asserted in the same cycle, both take effect. count_o changes by (alloc − pop).
- Head outputs are driven combinationally from entry[rd_ptr]. They are don't-care while empty_o=1.
- snoop_hit_o is combinational: the OR over valid entries of the word match with snoop_adr_i.
  - The entry being popped this cycle still counts.
  - A store being written this cycle does not count.
- Reset clears rd_ptr, wr_ptr and all valid bits. Data fields are not reset.

## Timing
- Reset values: empty_o=1, full_o=0, count_o=0, snoop_hit_o=0. Head outputs are undefined and must not be consumed.
- Write to head visibility: an entry written in cycle N appears on the head outputs and in snoop_hit_o in cycle N+1. There is no same-cycle bypass.
- A merge into an entry that is currently the head changes dat_o/bsel_o/pc_o in the next cycle.
- full_o, empty_o and count_o reflect registered pointers and update one cycle after the causing event.
- Reset asserted mid-operation discards all entries at the next edge, regardless of write_i or read_i.

## Test plan
- Reset, then 16 writes to distinct words (depth 16) -> count_o counts 1..16; full_o=1 after the 16th. A 17th write with read_i=0 is dropped and count_o stays 16.
- Write adr 0x100 bsel 0001 dat 0x000000AA, then adr 0x102 bsel 0100 dat 0x00BB0000 -> count_o=1, bsel_o=0101, dat_o=0x00BB00AA, pc_o = second pc.
- Same pair with atomic_i=1 on the second write, or with OPTION_STORE_COMBINE=0 -> count_o=2 and no merge.
- count_o=1 at word 0x200; read_i and write_i to 0x204 in the same cycle -> the head is popped, a new entry is allocated and count_o=1 with adr_o=0x204. With write to 0x200 at count_o=1 and read_i=1 -> the write allocates a new entry and does not merge.
- Entries at 0x300 and 0x400: snoop_adr_i=0x402 -> snoop_hit_o=1; snoop_adr_i=0x500 -> snoop_hit_o=0; after both are popped, snoop 0x300 -> 0.
- Fill to 10 entries, assert rst for one cycle while write_i=1 and read_i=1 -> the next cycle shows empty_o=1, count_o=0, snoop_hit_o=0.

Source files
------------

// File: rtl/mor1kx_store_buffer_combining.sv
// mor1kx_store_buffer_combining
//   Register-based in-order store buffer sitting between the LSU and the data
//   bus interface. A new store to the same word as the youngest queued entry
//   is merged into it (byte-lane wise) instead of taking a new slot. A snoop
//   port reports whether any queued store overlaps a load's word address so
//   the LSU can hold that load until the store has drained.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   pc_i/adr_i/dat_i/bsel_i   incoming store (data lane-aligned)
//   atomic_i                  store is l.swa, never merged
//   write_i / read_i          push-or-merge / pop head
//   pc_o/adr_o/dat_o/bsel_o/atomic_o   head entry (don't-care when empty)
//   snoop_adr_i, snoop_hit_o  load word-overlap check against valid entries
//   count_o, full_o, empty_o  occupancy from registered pointers

// One byte lane of the merge datapath: enabled lanes take the new byte.
module mor1kx_sbc_lane (
  input  logic       sel,
  input  logic [7:0] old_byte,
  input  logic [7:0] new_byte,
  output logic [7:0] merged
);
  assign merged = sel ? new_byte : old_byte;
endmodule

module mor1kx_store_buffer_combining #(
  parameter int DEPTH_WIDTH          = 4,
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int OPTION_STORE_COMBINE = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [OPTION_OPERAND_WIDTH-1:0] pc_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] dat_i,
  input  logic [OPTION_OPERAND_WIDTH/8-1:0] bsel_i,
  input  logic                            atomic_i,
  input  logic                            write_i,
  input  logic                            read_i,
  output logic [OPTION_OPERAND_WIDTH-1:0] pc_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] adr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] dat_o,
  output logic [OPTION_OPERAND_WIDTH/8-1:0] bsel_o,
  output logic                            atomic_o,
  input  logic [OPTION_OPERAND_WIDTH-1:0] snoop_adr_i,
  output logic                            snoop_hit_o,
  output logic [DEPTH_WIDTH:0]            count_o,
  output logic                            full_o,
  output logic                            empty_o
);
  localparam int DEPTH = 1 << DEPTH_WIDTH;
  localparam int W     = OPTION_OPERAND_WIDTH;
  localparam int BW    = W / 8;
  localparam int LSB   = $clog2(BW);
  localparam bit COMBINE = (OPTION_STORE_COMBINE != 0);

  localparam logic [DEPTH_WIDTH:0]   PTR_ONE  = (DEPTH_WIDTH+1)'(1);
  localparam logic [DEPTH_WIDTH:0]   FULL_CNT = (DEPTH_WIDTH+1)'(DEPTH);
  localparam logic [DEPTH_WIDTH-1:0] IDX_ONE  = DEPTH_WIDTH'(1);

  typedef struct packed {
    logic [W-1:0]  pc;
    logic [W-1:0]  adr;
    logic [W-1:0]  dat;
    logic [BW-1:0] bsel;
    logic          atomic;
  } st_req_t;

  st_req_t              mem [DEPTH];
  logic [DEPTH-1:0]     valid_q;
  logic [DEPTH_WIDTH:0] rd_ptr, wr_ptr;

  logic [DEPTH_WIDTH-1:0] rd_idx, wr_idx, tail_idx;
  logic                   pop, merge, alloc, tail_match;
  logic [W-1:0]           merged_dat;

  // Lane bits of the snoop address are irrelevant to a word compare.
  logic snoop_lane_unused;
  assign snoop_lane_unused = ^snoop_adr_i[LSB-1:0];

  assign rd_idx   = rd_ptr[DEPTH_WIDTH-1:0];
  assign wr_idx   = wr_ptr[DEPTH_WIDTH-1:0];
  assign tail_idx = wr_idx - IDX_ONE;

  // Pointers carry one extra bit so that full and empty are distinguishable.
  assign count_o = wr_ptr - rd_ptr;
  assign full_o  = (count_o == FULL_CNT);
  assign empty_o = (count_o == '0);

  assign tail_match = (mem[tail_idx].adr[W-1:LSB] == adr_i[W-1:LSB]);

  // Merging into the single entry while it is being popped would lose the
  // new bytes, so that case allocates a fresh entry instead.
  assign merge = COMBINE && write_i && !empty_o && tail_match && !atomic_i &&
                 !mem[tail_idx].atomic && !(read_i && count_o == PTR_ONE);
  assign pop   = read_i && !empty_o;
  assign alloc = write_i && !merge && (!full_o || read_i);

  for (genvar b = 0; b < BW; b++) begin : g_lane
    mor1kx_sbc_lane u_lane (
      .sel      (bsel_i[b]),
      .old_byte (mem[tail_idx].dat[8*b +: 8]),
      .new_byte (dat_i[8*b +: 8]),
      .merged   (merged_dat[8*b +: 8])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      valid_q <= '0;
    end else begin
      if (pop) begin
        rd_ptr          <= rd_ptr + PTR_ONE;
        valid_q[rd_idx] <= 1'b0;
      end
      // When full, the pop and alloc hit the same slot; alloc must win.
      if (alloc) begin
        wr_ptr          <= wr_ptr + PTR_ONE;
        valid_q[wr_idx] <= 1'b1;
      end
    end
  end

  // Payload is not reset: entries are only ever observed through valid_q
  // and the pointers.
  always_ff @(posedge clk) begin
    if (alloc) begin
      mem[wr_idx] <= '{pc: pc_i, adr: adr_i, dat: dat_i, bsel: bsel_i,
                       atomic: atomic_i};
    end
    if (merge) begin
      mem[tail_idx].dat  <= merged_dat;
      mem[tail_idx].bsel <= mem[tail_idx].bsel | bsel_i;
      mem[tail_idx].pc   <= pc_i;
    end
  end

  assign pc_o     = mem[rd_idx].pc;
  assign adr_o    = mem[rd_idx].adr;
  assign dat_o    = mem[rd_idx].dat;
  assign bsel_o   = mem[rd_idx].bsel;
  assign atomic_o = mem[rd_idx].atomic;

  // Registered state only: a store written this cycle is not yet visible,
  // an entry popped this cycle still is.
  always_comb begin
    snoop_hit_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && mem[i].adr[W-1:LSB] == snoop_adr_i[W-1:LSB])
        snoop_hit_o = 1'b1;
    end
  end

endmodule
